// File: rtl/branch_predictor.sv
// Fetch-stage predictor: direct-mapped BTB with a 2-bit counter per entry.
// Define BRANCH_PREDICTOR_PERF_EN to add branch/mispredict event counters.
module branch_predictor #(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 64,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PCF,
    output logic            predictTakenF,
    output logic [XLEN-1:0] predictedTargetF,
    input  logic            updateE,
    input  logic            isJumpE,
    input  logic [XLEN-1:0] PCE,
    input  logic            branchTakenE,
    input  logic [XLEN-1:0] targetE,
    input  logic            predTakenE,
    input  logic [XLEN-1:0] predTargetE,
    output logic            mispredictE,
    output logic [XLEN-1:0] redirectPCE
`ifdef BRANCH_PREDICTOR_PERF_EN
    ,
    output logic [31:0]     branchCount,
    output logic [31:0]     mispredictCount
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;

    assign f_idx = PCF[IDX_W+1:2];
    assign f_tag = PCF[XLEN-1:IDX_W+2];
    assign f_hit = valid[f_idx] && (tag_q[f_idx] == f_tag);

    assign predictTakenF    = f_hit & ctr_q[f_idx][1];
    assign predictedTargetF = predictTakenF ? target_q[f_idx]
                                            : PCF + XLEN'(4);

    assign e_idx = PCE[IDX_W+1:2];
    assign e_tag = PCE[XLEN-1:IDX_W+2];
    assign e_hit = valid[e_idx] && (tag_q[e_idx] == e_tag);

    assign mispredictE = updateE &
                         ((predTakenE != branchTakenE) |
                          (branchTakenE & (predTargetE != targetE)));
    assign redirectPCE = branchTakenE ? targetE : PCE + XLEN'(4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (updateE) begin
            if (e_hit) begin
                if (isJumpE) begin
                    ctr_q[e_idx] <= 2'b11;
                end else if (branchTakenE) begin
                    if (ctr_q[e_idx] != 2'b11) begin
                        ctr_q[e_idx] <= ctr_q[e_idx] + 2'd1;
                    end
                end else if (ctr_q[e_idx] != 2'b00) begin
                    ctr_q[e_idx] <= ctr_q[e_idx] - 2'd1;
                end
            end else if (branchTakenE) begin
                valid[e_idx] <= 1'b1;
                ctr_q[e_idx] <= isJumpE ? 2'b11 : 2'b10;
            end
        end
    end

    // Tag/target need no reset: they are only read behind a set valid bit.
    always_ff @(posedge clk) begin
        if (rst_n && updateE && branchTakenE) begin
            tag_q[e_idx]    <= e_tag;
            target_q[e_idx] <= targetE;
        end
    end

`ifdef BRANCH_PREDICTOR_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branchCount     <= '0;
            mispredictCount <= '0;
        end else begin
            if (updateE) begin
                branchCount <= branchCount + 32'd1;
            end
            if (mispredictE) begin
                mispredictCount <= mispredictCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor for the RV32I pipeline: direct-mapped branch target buffer (BTB) plus 2-bit saturating counter per entry.
- Fetch issues a combinational lookup on PCF and receives a predicted direction and target.
- Execute reports each resolved branch or jump; the block trains its tables and flags mispredictions so the hazard unit can flush and redirect.

Parameters:
- XLEN, 32, datapath/PC width.
- ENTRIES, 64, BTB/counter entries; power of 2, minimum 4. IDX_W = log2(ENTRIES).
- CTR_INIT, 2'b01, counter value written on reset (weakly not-taken).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- PCF  input  XLEN  fetch PC to look up
- predictTakenF  output  1  predicted taken
- predictedTargetF  output  XLEN  predicted target; PCF+4 when not predicted taken
- updateE  input  1  resolved control-transfer instruction in Execute this cycle
- isJumpE  input  1  instruction is unconditional (jal/jalr); valid with updateE
- PCE  input  XLEN  PC of resolved instruction
- branchTakenE  input  1  actual direction (from branch comparator; forced 1 for jumps)
- targetE  input  XLEN  actual target address
- predTakenE  input  1  prediction made at fetch, piped to Execute
- predTargetE  input  XLEN  predicted target, piped to Execute
- mispredictE  output  1  redirect required
- redirectPCE  output  XLEN  correct next PC

Behaviour:
- Indexing: idx = PC[IDX_W+1:2]; tag = PC[XLEN-1:IDX_W+2]. PC[1:0] is ignored.
- Per-entry state: valid, tag, target (XLEN), ctr (2 bits).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational, from registered state):
  - hitF = valid[idx] & tag match.
  - predictTakenF = hitF & ctr[idx][1].
  - predictedTargetF = predictTakenF ? target[idx] : PCF+4.
  - All arithmetic is modulo 2^XLEN; PCF+4 wraps.
- Misprediction (combinational, gated by updateE; 0 when updateE=0):
  - mispredictE = updateE & ((predTakenE != branchTakenE) | (branchTakenE & predTargetE != targetE)).
  - redirectPCE = branchTakenE ? targetE : PCE+4.
- Update (at posedge when updateE=1 and rst_n=1):
  - Hit, conditional branch: ctr increments on taken, decrements on not-taken, saturating at 11/00. Target is overwritten with targetE when taken.
  - Hit, jump: ctr := 11; target := targetE.
  - Miss, taken: allocate the entry (replacing any resident entry): valid=1, tag, target=targetE, ctr = isJumpE ? 11 : 10.
  - Miss, not-taken: no state change.
- Simultaneous lookup and update to the same index: lookup returns the pre-update state; the new state is visible the next cycle. No bypass.
- Latency: update-to-visible is 1 cycle. Lookup is 0 cycles.
- Reset (rst_n=0 at posedge):
  - All valid := 0; all ctr := CTR_INIT; targets and tags don't-care.
  - Completes in one cycle. An updateE asserted in the same cycle is dropped.
  - Output values after reset: predictTakenF = 0; predictedTargetF = PCF+4. mispredictE and redirectPCE remain pure functions of the Execute inputs.
- Reset asserted mid-training discards all history; no partial state survives.
- Aliasing: two PCs that share an idx but differ in tag never hit each other's entry; the newest taken allocation wins.

Optional Feature:
- Macro: BRANCH_PREDICTOR_PERF_EN.
- When defined:
  - Adds outputs branchCount (32) and mispredictCount (32).
  - branchCount increments on every updateE; mispredictCount increments when mispredictE=1.
  - Both counters wrap modulo 2^32, clear to 0 on reset, and are registered with 1-cycle visibility.
- When undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then PCF=0x00000100 → predictTakenF=0, predictedTargetF=0x00000104.
- Update PCE=0x100, taken, targetE=0x80, predTakenE=0 → mispredictE=1, redirectPCE=0x80. Next cycle, PCF=0x100 → predictTakenF=1, predictedTargetF=0x80.
- Counter hysteresis (from the previous step, ctr=10): not-taken update → ctr=01, prediction NT. Two taken updates → ctr=11. One not-taken update → ctr=10, still predicts taken. Three not-taken updates → ctr=00; a further not-taken update keeps ctr=00 (saturation).
- Aliasing: train 0x100 taken to 0x80, then look up 0x100+ENTRIES*4 (0x200 with defaults) → no hit, predictedTargetF=0x204. A taken update at 0x200 targeting 0x300 evicts the entry, so 0x100 now predicts NT.
- Same-cycle update and lookup of 0x100 (first taken update) → that cycle predictTakenF=0; the following cycle predictTakenF=1.
- Jump (isJumpE=1) at 0x40, target 0x400, predicted correctly → mispredictE=0, ctr=11. With the macro defined: branchCount increments by 1 and mispredictCount is unchanged.
